muldiv_unit: RTL

- Iterative RV32M multiply/divide unit that sits directly downstream of the ALU source mux, beside the ALU.
- Consumes SrcA (register-file RD1) and SrcB (the ALU-mux output B) and returns a 32-bit result to the result/writeback mux.
- Exposes a start/busy/done handshake so the control unit stalls the PC while an M-extension instruction completes.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit: op codes, FSM states, defaults.
// Also holds the per-op signedness decode used when conditioning operands.
package muldiv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: absolute value on the way in, sign restore on the way out.
// Purely combinational, zero latency, no flow control.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: 34-edge latency for normal ops, 1 edge for divide special cases.
// Start is only sampled in IDLE; the unit ignores requests while busy or presenting done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_by_zero, div_ovf, div_special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Operand conditioning: iterate on magnitudes, remember the signs for the fixup step.
    assign a_neg = op_a_signed(funct3) & A[XLEN-1];
    assign b_neg = op_b_signed(funct3) & B[XLEN-1];

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.din(A), .neg(a_neg), .dout(a_mag));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.din(B), .neg(b_neg), .dout(b_mag));

    assign div_by_zero = (B == '0);
    assign div_ovf     = ~funct3[0] && (A == MIN_NEG) && (B == ALL_ONES);
    assign div_special = funct3[2] && (div_by_zero || div_ovf);

    // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = funct3[1] ? A : ALL_ONES;
        end else begin
            special_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // hi/lo double as product {hi,lo} for multiply and as remainder/quotient for divide.
    assign mul_addend = lo_q[0] ? opb_q : '0;
    assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    assign div_shift  = {hi_q, lo_q[XLEN-1]};
    assign div_diff   = div_shift - {1'b0, opb_q};
    assign div_ge     = ~div_diff[XLEN];

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.din({hi_q, lo_q}), .neg(neg_res_q), .dout(prod_fix));
    muldiv_sign_fix #(.W(XLEN))   u_fix_quo  (.din(lo_q),         .neg(neg_res_q), .dout(quo_fix));
    muldiv_sign_fix #(.W(XLEN))   u_fix_rem  (.din(hi_q),         .neg(neg_rem_q), .dout(rem_fix));

    always_comb begin
        fix_res = '0;
        if (!f3_q[2]) begin
            fix_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fix_res = f3_q[1] ? rem_fix : quo_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d = funct3;
                    if (div_special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        opb_d     = b_mag;
                        hi_d      = '0;
                        lo_d      = a_mag;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(XLEN);
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (f3_q[2]) begin
                    hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
